// File: rtl/rip_csr_exec.sv
// ---------------------------------------------------------------------------
// rip_csr_exec
//
// Execute-side partner of the CSR register file. Decodes the Zicsr
// instructions (CSRRW/RS/RC and their immediate forms), computes the new
// CSR value and the rd write-back value, and owns the MA-stage register
// that drives the CSR file write port.
//
// An instruction in EX that targets the CSR currently waiting in MA takes
// its old value from the in-flight MA write data instead of the stale file
// read. Non-adjacent instructions rely on the file's own read-during-write
// bypass.
//
// Optional build macro:
//   RIP_CSR_RO_CHECK_EN - when defined, a write request to a read-only CSR
//                         (csr_num[11:10] == 2'b11) is flagged illegal and
//                         neither the CSR nor the GPR is written.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ex_valid       CSR instruction present in EX
//   ex_funct3      Zicsr funct3
//   ex_csr_num     target CSR address
//   ex_rs1_idx     rs1 index / zero-extended uimm for immediate forms
//   ex_rs1_data    rs1 value (already GPR-forwarded)
//   ex_rd_idx      destination GPR
//   ex_csr_rdata   old CSR value read by the file
//   stall          hold the MA register, EX not accepted
//   flush          kill the instruction entering MA
//   ma_valid       MA register holds an instruction
//   ma_rd_idx      destination GPR
//   ma_rd_wen      GPR write-back enable
//   ma_rd_data     old CSR value, written to rd
//   ma_csr_num     CSR file write address
//   ma_wen         CSR file write enable (one pulse per instruction)
//   ma_csr_din     CSR file write data
//   ma_illegal     illegal-instruction flag to the trap logic
// ---------------------------------------------------------------------------
module rip_csr_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [2:0]      ex_funct3,
  input  logic [11:0]     ex_csr_num,
  input  logic [4:0]      ex_rs1_idx,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [4:0]      ex_rd_idx,
  input  logic [XLEN-1:0] ex_csr_rdata,
  input  logic            stall,
  input  logic            flush,
  output logic            ma_valid,
  output logic [4:0]      ma_rd_idx,
  output logic            ma_rd_wen,
  output logic [XLEN-1:0] ma_rd_data,
  output logic [11:0]     ma_csr_num,
  output logic            ma_wen,
  output logic [XLEN-1:0] ma_csr_din,
  output logic            ma_illegal
);

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  // Write request of the instruction held in MA (before illegal gating).
  logic            write_req_r;

  logic [XLEN-1:0] src_s;
  logic [XLEN-1:0] old_s;
  logic [XLEN-1:0] new_s;
  logic            fwd_hit_s;
  logic            write_req_s;
  logic            op_illegal_s;
  logic            ro_illegal_s;
  logic            illegal_s;

  // Source operand selection and self-forwarding of the in-flight MA write.
  always_comb begin
    src_s     = {XLEN{1'b0}};
    fwd_hit_s = 1'b0;
    old_s     = ex_csr_rdata;
    if (ex_funct3[2]) begin
      src_s = {{(XLEN-5){1'b0}}, ex_rs1_idx};
    end else begin
      src_s = ex_rs1_data;
    end
    fwd_hit_s = ma_valid && write_req_r && !ma_illegal &&
                (ma_csr_num == ex_csr_num);
    if (fwd_hit_s) begin
      old_s = ma_csr_din;
    end else begin
      old_s = ex_csr_rdata;
    end
  end

  // Operation decode: new CSR value and whether a write is requested.
  // Set/clear with rs1 == x0 (or uimm == 0) is a pure read.
  always_comb begin
    new_s        = old_s;
    write_req_s  = 1'b0;
    op_illegal_s = 1'b0;
    case (ex_funct3)
      F3_RW, F3_RWI: begin
        new_s       = src_s;
        write_req_s = 1'b1;
      end
      F3_RS, F3_RSI: begin
        new_s       = old_s | src_s;
        write_req_s = (ex_rs1_idx != 5'd0);
      end
      F3_RC, F3_RCI: begin
        new_s       = old_s & ~src_s;
        write_req_s = (ex_rs1_idx != 5'd0);
      end
      default: begin
        // funct3 000 / 100 are not Zicsr encodings.
        new_s        = old_s;
        write_req_s  = 1'b0;
        op_illegal_s = 1'b1;
      end
    endcase
  end

  // Optional read-only CSR write check; only an actual write request traps.
  always_comb begin
    ro_illegal_s = 1'b0;
`ifdef RIP_CSR_RO_CHECK_EN
    if (write_req_s && (ex_csr_num[11:10] == 2'b11)) begin
      ro_illegal_s = 1'b1;
    end else begin
      ro_illegal_s = 1'b0;
    end
`else
    ro_illegal_s = 1'b0;
`endif
    illegal_s = op_illegal_s | ro_illegal_s;
  end

  // MA pipeline register: flush beats stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_valid    <= 1'b0;
      ma_illegal  <= 1'b0;
      write_req_r <= 1'b0;
      ma_rd_idx   <= 5'd0;
      ma_rd_data  <= {XLEN{1'b0}};
      ma_csr_num  <= 12'd0;
      ma_csr_din  <= {XLEN{1'b0}};
    end else if (flush) begin
      ma_valid    <= 1'b0;
      ma_illegal  <= 1'b0;
      write_req_r <= 1'b0;
    end else if (!stall) begin
      ma_valid    <= ex_valid;
      ma_illegal  <= ex_valid & illegal_s;
      write_req_r <= ex_valid & write_req_s;
      ma_rd_idx   <= ex_rd_idx;
      ma_rd_data  <= old_s;
      ma_csr_num  <= ex_csr_num;
      ma_csr_din  <= new_s;
    end
  end

  // The write strobe is masked while stalled so a held instruction writes
  // exactly once, in the cycle it leaves MA.
  assign ma_wen    = ma_valid && write_req_r && !ma_illegal && !stall;
  assign ma_rd_wen = ma_valid && (ma_rd_idx != 5'd0) && !ma_illegal;

endmodule

// File: tb/tb_rip_csr_exec.sv
module tb_rip_csr_exec;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            ex_valid;
  logic [2:0]      ex_funct3;
  logic [11:0]     ex_csr_num;
  logic [4:0]      ex_rs1_idx;
  logic [XLEN-1:0] ex_rs1_data;
  logic [4:0]      ex_rd_idx;
  logic [XLEN-1:0] ex_csr_rdata;
  logic            stall;
  logic            flush;
  logic            ma_valid;
  logic [4:0]      ma_rd_idx;
  logic            ma_rd_wen;
  logic [XLEN-1:0] ma_rd_data;
  logic [11:0]     ma_csr_num;
  logic            ma_wen;
  logic [XLEN-1:0] ma_csr_din;
  logic            ma_illegal;

  int checks = 0;
  int errors = 0;

  rip_csr_exec #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_funct3    (ex_funct3),
    .ex_csr_num   (ex_csr_num),
    .ex_rs1_idx   (ex_rs1_idx),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rd_idx    (ex_rd_idx),
    .ex_csr_rdata (ex_csr_rdata),
    .stall        (stall),
    .flush        (flush),
    .ma_valid     (ma_valid),
    .ma_rd_idx    (ma_rd_idx),
    .ma_rd_wen    (ma_rd_wen),
    .ma_rd_data   (ma_rd_data),
    .ma_csr_num   (ma_csr_num),
    .ma_wen       (ma_wen),
    .ma_csr_din   (ma_csr_din),
    .ma_illegal   (ma_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ex(input logic v, input logic [2:0] f3, input logic [11:0] csr,
                        input logic [4:0] rs1, input logic [31:0] rs1d,
                        input logic [4:0] rd, input logic [31:0] rdata);
    ex_valid     = v;
    ex_funct3    = f3;
    ex_csr_num   = csr;
    ex_rs1_idx   = rs1;
    ex_rs1_data  = rs1d;
    ex_rd_idx    = rd;
    ex_csr_rdata = rdata;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_ex(1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    checks++; if (ma_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ma_valid); end
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", ma_wen); end
    rst_n = 1'b1;
    // Load a valid write, then reset mid-cycle.
    set_ex(1'b1, 3'b001, 12'h100, 5'd2, 32'h0000_0055, 5'd1, 32'h0000_0011);
    step();
    checks++; if (ma_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b want 1", ma_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ma_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b want 0", ma_valid); end
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL async_rst_wen: got %b want 0", ma_wen); end
    checks++; if (ma_rd_wen !== 1'b0) begin errors++; $display("FAIL async_rst_rd_wen: got %b want 0", ma_rd_wen); end
    checks++; if (ma_illegal !== 1'b0) begin errors++; $display("FAIL async_rst_illegal: got %b want 0", ma_illegal); end
    checks++; if (ma_rd_data !== 32'h0) begin errors++; $display("FAIL async_rst_rd_data: got %h want 0", ma_rd_data); end
    checks++; if (ma_csr_din !== 32'h0) begin errors++; $display("FAIL async_rst_din: got %h want 0", ma_csr_din); end
    checks++; if (ma_csr_num !== 12'h0) begin errors++; $display("FAIL async_rst_num: got %h want 0", ma_csr_num); end
    checks++; if (ma_rd_idx !== 5'd0) begin errors++; $display("FAIL async_rst_rd_idx: got %0d want 0", ma_rd_idx); end
    set_ex(1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL post_rst_wen: got %b want 0", ma_wen); end
  endtask

  task automatic test_csrrs;
    // CSRRS x5, 0x340, x6
    set_ex(1'b1, 3'b010, 12'h340, 5'd6, 32'h0000_000F, 5'd5, 32'h0000_00F0);
    step();
    checks++; if (ma_rd_data !== 32'h0000_00F0) begin errors++; $display("FAIL rs_rd_data: got %h want 000000f0", ma_rd_data); end
    checks++; if (ma_csr_din !== 32'h0000_00FF) begin errors++; $display("FAIL rs_din: got %h want 000000ff", ma_csr_din); end
    checks++; if (ma_wen !== 1'b1) begin errors++; $display("FAIL rs_wen: got %b want 1", ma_wen); end
    checks++; if (ma_rd_wen !== 1'b1) begin errors++; $display("FAIL rs_rd_wen: got %b want 1", ma_rd_wen); end
    checks++; if (ma_rd_idx !== 5'd5) begin errors++; $display("FAIL rs_rd_idx: got %0d want 5", ma_rd_idx); end
    checks++; if (ma_csr_num !== 12'h340) begin errors++; $display("FAIL rs_num: got %h want 340", ma_csr_num); end
  endtask

  task automatic test_rs1_zero;
    // CSRRC x0, 0x300, x0 : pure read, no writes at all
    set_ex(1'b1, 3'b011, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0000_1234);
    step();
    checks++; if (ma_valid !== 1'b1) begin errors++; $display("FAIL rc0_valid: got %b want 1", ma_valid); end
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL rc0_wen: got %b want 0", ma_wen); end
    checks++; if (ma_rd_wen !== 1'b0) begin errors++; $display("FAIL rc0_rd_wen: got %b want 0", ma_rd_wen); end
    checks++; if (ma_rd_data !== 32'h0000_1234) begin errors++; $display("FAIL rc0_rd_data: got %h want 00001234", ma_rd_data); end
    // CSRRWI x0, 0x300, 3 : writes even with rd = x0
    set_ex(1'b1, 3'b101, 12'h300, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'h0000_1234);
    step();
    checks++; if (ma_wen !== 1'b1) begin errors++; $display("FAIL rwi_wen: got %b want 1", ma_wen); end
    checks++; if (ma_csr_din !== 32'h0000_0003) begin errors++; $display("FAIL rwi_din: got %h want 00000003", ma_csr_din); end
    checks++; if (ma_rd_wen !== 1'b0) begin errors++; $display("FAIL rwi_rd_wen: got %b want 0", ma_rd_wen); end
  endtask

  task automatic test_back_to_back;
    // CSRRWI x0, 0x341, 5
    set_ex(1'b1, 3'b101, 12'h341, 5'd5, 32'h0, 5'd0, 32'h0);
    step();
    checks++; if (ma_csr_din !== 32'h0000_0005) begin errors++; $display("FAIL b2b_first_din: got %h want 00000005", ma_csr_din); end
    // CSRRSI x7, 0x341, 8 with stale file read of 0
    set_ex(1'b1, 3'b110, 12'h341, 5'd8, 32'h0, 5'd7, 32'h0);
    step();
    checks++; if (ma_rd_data !== 32'h0000_0005) begin errors++; $display("FAIL b2b_rd_data: got %h want 00000005", ma_rd_data); end
    checks++; if (ma_csr_din !== 32'h0000_000D) begin errors++; $display("FAIL b2b_din: got %h want 0000000d", ma_csr_din); end
    checks++; if (ma_rd_wen !== 1'b1) begin errors++; $display("FAIL b2b_rd_wen: got %b want 1", ma_rd_wen); end
  endtask

  task automatic test_stall_flush;
    int pulses;
    // CSRRW x2, 0x305, rs1 = 0xAAAA
    set_ex(1'b1, 3'b001, 12'h305, 5'd4, 32'h0000_AAAA, 5'd2, 32'h0);
    step();
    stall = 1'b1;
    set_ex(1'b1, 3'b001, 12'h306, 5'd4, 32'h0000_BBBB, 5'd3, 32'h0);
    #1;
    pulses = 0;
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL stall_wen0: got %b want 0", ma_wen); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (ma_wen === 1'b1) pulses++;
      checks++; if (ma_csr_din !== 32'h0000_AAAA) begin errors++; $display("FAIL stall_hold_din[%0d]: got %h want 0000aaaa", i, ma_csr_din); end
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL stall_no_pulse: got %0d pulses want 0", pulses); end
    stall = 1'b0;
    #1;
    checks++; if (ma_wen !== 1'b1) begin errors++; $display("FAIL release_wen: got %b want 1", ma_wen); end
    checks++; if (ma_csr_num !== 12'h305) begin errors++; $display("FAIL release_num: got %h want 305", ma_csr_num); end
    step();
    checks++; if (ma_csr_num !== 12'h306) begin errors++; $display("FAIL next_num: got %h want 306", ma_csr_num); end
    checks++; if (ma_csr_din !== 32'h0000_BBBB) begin errors++; $display("FAIL next_din: got %h want 0000bbbb", ma_csr_din); end
    // Flush together with stall kills the held instruction without a write.
    stall = 1'b1; flush = 1'b1;
    #1;
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL flush_cycle_wen: got %b want 0", ma_wen); end
    step();
    stall = 1'b0; flush = 1'b0;
    set_ex(1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    checks++; if (ma_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ma_valid); end
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL flush_wen: got %b want 0", ma_wen); end
    step();
    checks++; if (ma_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", ma_valid); end
  endtask

  task automatic test_read_only;
    // CSRRW x1, 0xC00, x2
    set_ex(1'b1, 3'b001, 12'hC00, 5'd2, 32'h0000_0077, 5'd1, 32'h0000_0001);
    step();
`ifdef RIP_CSR_RO_CHECK_EN
    checks++; if (ma_illegal !== 1'b1) begin errors++; $display("FAIL ro_illegal: got %b want 1", ma_illegal); end
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL ro_wen: got %b want 0", ma_wen); end
    checks++; if (ma_rd_wen !== 1'b0) begin errors++; $display("FAIL ro_rd_wen: got %b want 0", ma_rd_wen); end
`else
    checks++; if (ma_illegal !== 1'b0) begin errors++; $display("FAIL ro_illegal: got %b want 0", ma_illegal); end
    checks++; if (ma_wen !== 1'b1) begin errors++; $display("FAIL ro_wen: got %b want 1", ma_wen); end
    checks++; if (ma_csr_din !== 32'h0000_0077) begin errors++; $display("FAIL ro_din: got %h want 00000077", ma_csr_din); end
`endif
    // CSRRS x3, 0xC01, x0 : read-only read stays legal in both builds
    set_ex(1'b1, 3'b010, 12'hC01, 5'd0, 32'h0, 5'd3, 32'h0000_0042);
    step();
    checks++; if (ma_illegal !== 1'b0) begin errors++; $display("FAIL ro_read_illegal: got %b want 0", ma_illegal); end
    checks++; if (ma_rd_wen !== 1'b1) begin errors++; $display("FAIL ro_read_rd_wen: got %b want 1", ma_rd_wen); end
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL ro_read_wen: got %b want 0", ma_wen); end
    checks++; if (ma_rd_data !== 32'h0000_0042) begin errors++; $display("FAIL ro_read_data: got %h want 00000042", ma_rd_data); end
  endtask

  task automatic test_illegal;
    set_ex(1'b1, 3'b100, 12'h340, 5'd6, 32'h1, 5'd4, 32'h0);
    step();
    checks++; if (ma_illegal !== 1'b1) begin errors++; $display("FAIL f3_100_illegal: got %b want 1", ma_illegal); end
    checks++; if (ma_wen !== 1'b0) begin errors++; $display("FAIL f3_100_wen: got %b want 0", ma_wen); end
    checks++; if (ma_rd_wen !== 1'b0) begin errors++; $display("FAIL f3_100_rd_wen: got %b want 0", ma_rd_wen); end
    set_ex(1'b1, 3'b000, 12'h340, 5'd6, 32'h1, 5'd4, 32'h0);
    step();
    checks++; if (ma_illegal !== 1'b1) begin errors++; $display("FAIL f3_000_illegal: got %b want 1", ma_illegal); end
    set_ex(1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    checks++; if (ma_illegal !== 1'b0) begin errors++; $display("FAIL idle_illegal: got %b want 0", ma_illegal); end
  endtask

  initial begin
    test_reset();
    test_csrrs();
    test_rs1_zero();
    test_back_to_back();
    test_stall_flush();
    test_read_only();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
